// File: rtl/bist_engine.sv
// Logic-BIST controller: pattern/scan LFSRs, scan shift/capture sequencing, MISR compaction, golden compare.
// Define BIST_SIG_OUT_EN to expose the live MISR as sig_out_o (held in DONE as the final signature).
module bist_engine #(
  parameter int                 N_IN       = 3,
  parameter int                 N_OUT      = 2,
  parameter int                 LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  LFSR_POLY  = 16'hB400,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = 16'hACE1,
  parameter int                 MISR_W     = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY  = 16'hD008,
  parameter int                 SCAN_LEN   = 8,
  parameter int                 N_PATTERNS = 64,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG = 16'h0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bist_start_i,
  input  logic [N_IN-1:0]  func_in_i,
  output logic [N_IN-1:0]  dut_in_o,
  output logic             scan_en_o,
  output logic             scan_in_o,
  input  logic             scan_out_i,
  input  logic [N_OUT-1:0] dut_out_i,
  output logic             running_o,
  output logic             bist_end_o,
  output logic             pass_fail_o
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [MISR_W-1:0] sig_out_o
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_UNLOAD  = 3'd4;
  localparam logic [2:0] ST_COMPARE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SCAN_RAW  = ~LFSR_SEED;
  localparam logic [LFSR_W-1:0] PAT_SEED  = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
  localparam logic [LFSR_W-1:0] SCAN_SEED = (SCAN_RAW == '0) ? LFSR_W'(1) : SCAN_RAW;

  localparam int BIT_W = $clog2(SCAN_LEN + 1);
  localparam int PAT_W = $clog2(N_PATTERNS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SCAN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(N_PATTERNS - 1);

  logic [2:0]        state_q, state_d;
  logic              start_q;
  logic [LFSR_W-1:0] pat_lfsr_q, pat_lfsr_d;
  logic [LFSR_W-1:0] scan_lfsr_q, scan_lfsr_d;
  logic [MISR_W-1:0] misr_q, misr_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]  pat_cnt_q, pat_cnt_d;
  logic              pass_q, pass_d;
  logic              start_rise;
  logic [MISR_W-1:0] misr_in;
  logic [MISR_W-1:0] misr_next;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
  endfunction

  assign start_rise = bist_start_i & ~start_q;
  assign misr_in    = MISR_W'({dut_out_i, scan_out_i});
  assign misr_next  = (misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0) ^ misr_in;

  always_comb begin
    state_d     = state_q;
    pat_lfsr_d  = pat_lfsr_q;
    scan_lfsr_d = scan_lfsr_q;
    misr_d      = misr_q;
    bit_cnt_d   = bit_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          state_d = ST_INIT;
          pass_d  = 1'b0;
        end
      end
      ST_INIT: begin
        pat_lfsr_d  = PAT_SEED;
        scan_lfsr_d = SCAN_SEED;
        misr_d      = '0;
        bit_cnt_d   = '0;
        pat_cnt_d   = '0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT, ST_UNLOAD: begin
        scan_lfsr_d = lfsr_step(scan_lfsr_q);
        misr_d      = misr_next;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          state_d   = (state_q == ST_SHIFT) ? ST_CAPTURE : ST_COMPARE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_CAPTURE: begin
        misr_d     = misr_next;
        pat_lfsr_d = lfsr_step(pat_lfsr_q);
        if (pat_cnt_q == PAT_LAST) begin
          state_d = ST_UNLOAD;
        end else begin
          pat_cnt_d = pat_cnt_q + PAT_W'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_COMPARE: begin
        pass_d  = (misr_q == GOLDEN_SIG);
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      pat_lfsr_q  <= PAT_SEED;
      scan_lfsr_q <= SCAN_SEED;
      misr_q      <= '0;
      bit_cnt_q   <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bist_start_i;
      pat_lfsr_q  <= pat_lfsr_d;
      scan_lfsr_q <= scan_lfsr_d;
      misr_q      <= misr_d;
      bit_cnt_q   <= bit_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
    end
  end

  assign running_o   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign scan_en_o   = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
  assign bist_end_o  = (state_q == ST_DONE);
  assign pass_fail_o = pass_q;
  assign scan_in_o   = running_o & scan_lfsr_q[0];
  assign dut_in_o    = running_o ? pat_lfsr_q[N_IN-1:0] : func_in_i;

`ifdef BIST_SIG_OUT_EN
  assign sig_out_o = misr_q;
`endif

endmodule

// File: tb/tb_bist_engine.sv
// Randomized bench for bist_engine: small full-scan DUT stand-in, cycle-indexed reference model, per-cycle compare.
module tb_bist_engine;
  localparam int S  = 3;
  localparam int NP = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] LPOLY = 16'hB400;
  localparam logic [15:0] MPOLY = 16'hD008;
  localparam int RUN_CYC     = NP * (S + 1);
  localparam int LAST_UNLOAD = RUN_CYC + S;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LPOLY : 16'h0);
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? MPOLY : 16'h0);
  endfunction

  function automatic logic [15:0] lpow(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lstep(v);
    return v;
  endfunction

  // Stand-in circuit under test: combinational outputs and capture function of the scan chain.
  function automatic logic [1:0] dut_comb(input logic [S-1:0] ch, input logic [2:0] din);
    return {(ch[0] & din[1]) | ch[S-1], ch[0] ^ din[0] ^ din[2]};
  endfunction

  function automatic logic [S-1:0] dut_cap(input logic [S-1:0] ch, input logic [2:0] din);
    return {ch[S-2:0] ^ {(S-1){din[1]}}, din[0] ^ din[2] ^ ch[S-1]};
  endfunction

  // Whole-run signature of the stand-in circuit, optionally with scan_out stuck at 0.
  function automatic logic [15:0] calc_sig(input bit stuck);
    logic [15:0] m, pl, sl;
    logic [S-1:0] ch;
    logic [1:0] dout;
    logic so;
    m = 16'h0; pl = SEED; sl = ~SEED; ch = '0;
    for (int p = 0; p <= NP; p++) begin
      for (int b = 0; b < S; b++) begin
        dout = dut_comb(ch, pl[2:0]);
        so   = stuck ? 1'b0 : ch[S-1];
        m    = mstep(m) ^ {13'h0, dout, so};
        ch   = {ch[S-2:0], sl[0]};
        sl   = lstep(sl);
      end
      if (p < NP) begin
        dout = dut_comb(ch, pl[2:0]);
        so   = stuck ? 1'b0 : ch[S-1];
        m    = mstep(m) ^ {13'h0, dout, so};
        ch   = dut_cap(ch, pl[2:0]);
        pl   = lstep(pl);
      end
    end
    return m;
  endfunction

  localparam logic [15:0] GOLDEN = calc_sig(1'b0);

  logic clk = 1'b0;
  logic rst_n, bist_start, fault;
  logic [2:0] func_in, dut_in;
  logic scan_en, scan_in, scan_out, running, bist_end, pass_fail;
  logic [1:0] dut_out;
  logic [S-1:0] chain;
  logic run_d;
`ifdef BIST_SIG_OUT_EN
  logic [15:0] sig_out;
  logic [15:0] first_sig;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bist_engine #(
    .N_IN(3), .N_OUT(2), .LFSR_W(16), .LFSR_POLY(LPOLY), .LFSR_SEED(SEED),
    .MISR_W(16), .MISR_POLY(MPOLY), .SCAN_LEN(S), .N_PATTERNS(NP), .GOLDEN_SIG(GOLDEN)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bist_start_i(bist_start), .func_in_i(func_in),
    .dut_in_o(dut_in), .scan_en_o(scan_en), .scan_in_o(scan_in), .scan_out_i(scan_out),
    .dut_out_i(dut_out), .running_o(running), .bist_end_o(bist_end), .pass_fail_o(pass_fail)
`ifdef BIST_SIG_OUT_EN
    , .sig_out_o(sig_out)
`endif
  );

  assign scan_out = fault ? 1'b0 : chain[S-1];
  assign dut_out  = dut_comb(chain, dut_in);

  // Chain starts from zero at the first running cycle so every run is reproducible.
  always @(posedge clk) begin
    run_d <= running;
    if (!running || !run_d) chain <= '0;
    else if (scan_en)       chain <= {chain[S-2:0], scan_in};
    else                    chain <= dut_cap(chain, dut_in);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycle index since the start-sampling edge decides the phase.
  logic        m_active, m_done, m_pass, m_prev;
  logic [15:0] m_misr;
  int          m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_prev <= 1'b0;
      m_misr <= 16'h0; m_cyc <= 0;
    end else begin
      m_prev <= bist_start;
      if (!m_active) begin
        if (bist_start && !m_prev) begin
          m_active <= 1'b1; m_done <= 1'b0; m_pass <= 1'b0; m_cyc <= 0;
        end
      end else begin
        if (m_cyc == 0) m_misr <= 16'h0;
        else if (m_cyc <= LAST_UNLOAD) m_misr <= mstep(m_misr) ^ {13'h0, dut_out, scan_out};
        else begin
          m_pass <= (m_misr == GOLDEN); m_active <= 1'b0; m_done <= 1'b1;
        end
        m_cyc <= m_cyc + 1;
      end
    end
  end

  int cc, pp, rr, jj;
  bit is_sh, is_un;
  logic [15:0] tmp;

  always @(negedge clk) begin
    chk("running", 32'(running), 32'(m_active));
    chk("bist_end", 32'(bist_end), 32'(m_done));
    chk("pass_fail", 32'(pass_fail), 32'(m_pass));
`ifdef BIST_SIG_OUT_EN
    chk("sig_out", 32'(sig_out), 32'(m_misr));
`endif
    if (m_active) begin
      cc = m_cyc; pp = NP; rr = 0; jj = 0; is_sh = 1'b0; is_un = 1'b0;
      if (cc >= 1 && cc <= RUN_CYC) begin
        pp = (cc - 1) / (S + 1); rr = (cc - 1) % (S + 1);
        is_sh = (rr < S); jj = pp * S + rr;
      end else if (cc > RUN_CYC && cc <= LAST_UNLOAD) begin
        is_un = 1'b1; jj = NP * S + (cc - RUN_CYC - 1);
      end
      chk("scan_en", 32'(scan_en), 32'(is_sh || is_un));
      if (is_sh || is_un) begin
        tmp = lpow(~SEED, jj);
        chk("scan_in", 32'(scan_in), 32'(tmp[0]));
      end
      if (cc > 0) begin
        tmp = lpow(SEED, pp);
        chk("dut_in_run", 32'(dut_in), 32'(tmp[2:0]));
      end
    end else begin
      chk("scan_en_idle", 32'(scan_en), 32'd0);
      chk("dut_in_mux", 32'(dut_in), 32'(func_in));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_bist(input bit pins, input bit hold, output int lat);
    bist_start = 1'b0; tick();
    bist_start = 1'b1; tick();
    if (!hold) bist_start = 1'b0;
    chk("running_1cyc", 32'(running), 32'd1);
    lat = 0;
    while (bist_end !== 1'b1 && lat < 200) begin
      func_in = 3'($urandom);
      if (!hold) bist_start = 1'($urandom_range(0, 1));
      if (pins) begin
        if (lat == 1) chk("pin_scan_in0", 32'(scan_in), 32'd0);
        if (lat == 2) chk("pin_scan_in1", 32'(scan_in), 32'd1);
        if (lat == 3) chk("pin_scan_in2", 32'(scan_in), 32'd1);
        if (lat == 4) chk("pin_cap0", 32'(dut_in), 32'h1);
        if (lat == 16) chk("pin_cap3", 32'(dut_in), 32'h4);
      end
      tick(); lat++;
    end
    if (!hold) bist_start = 1'b0;
    if (lat >= 200) chk("done_timeout", 32'(bist_end), 32'd1);
  endtask

  task automatic reset_check(input string nm);
    rst_n = 1'b0; #1;
    chk({nm, "_running"}, 32'(running), 32'd0);
    chk({nm, "_bist_end"}, 32'(bist_end), 32'd0);
    chk({nm, "_pass"}, 32'(pass_fail), 32'd0);
    chk({nm, "_scan_en"}, 32'(scan_en), 32'd0);
    chk({nm, "_scan_in"}, 32'(scan_in), 32'd0);
    chk({nm, "_dut_in"}, 32'(dut_in), 32'(func_in));
    tick(); rst_n = 1'b1; tick();
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; bist_start = 1'b0; fault = 1'b0; func_in = 3'($urandom);
    repeat (3) tick();
    reset_check("reset");

    func_in = 3'b101; tick();
    chk("mux_idle", 32'(dut_in), 32'h5);

    run_bist(1'b1, 1'b0, lat);
    chk("latency", 32'(lat), 32'd21);
    chk("pass_first", 32'(pass_fail), 32'd1);
`ifdef BIST_SIG_OUT_EN
    first_sig = sig_out;
`endif
    func_in = 3'b101; tick();
    chk("mux_done", 32'(dut_in), 32'h5);
    repeat (3) begin func_in = 3'($urandom); tick(); end

    run_bist(1'b0, 1'b1, lat);
    chk("pass_restart", 32'(pass_fail), 32'd1);
    repeat (5) tick();
    chk("held_no_retrigger", 32'(bist_end), 32'd1);
`ifdef BIST_SIG_OUT_EN
    chk("sig_restart", 32'(sig_out), 32'(first_sig));
`endif
    bist_start = 1'b0;

    fault = 1'b1;
    run_bist(1'b0, 1'b0, lat);
    chk("pass_stuck0", 32'(pass_fail), 32'd0);
`ifdef BIST_SIG_OUT_EN
    chk("sig_ne_golden", 32'(sig_out != GOLDEN), 32'd1);
`endif
    fault = 1'b0;

    run_bist(1'b0, 1'b0, lat);
    chk("pass_before_rst", 32'(pass_fail), 32'd1);
    reset_check("rst_done");

    bist_start = 1'b1; tick(); bist_start = 1'b0;
    repeat (7) tick();
    func_in = 3'($urandom);
    reset_check("rst_midrun");

    for (int it = 0; it < 20; it++) begin
      fault = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) begin func_in = 3'($urandom); tick(); end
      if ($urandom_range(0, 4) == 0) begin
        bist_start = 1'b1; tick(); bist_start = 1'b0;
        repeat ($urandom_range(1, 18)) tick();
        func_in = 3'($urandom);
        reset_check("rst_rand");
      end else begin
        run_bist(1'b0, 1'b0, lat);
        chk("latency_rand", 32'(lat), 32'd21);
        chk("pass_rand", 32'(pass_fail), 32'(!fault));
      end
    end
    fault = 1'b0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
